// File: rtl/aion_guardian_scheduler_if.sv
// Guardian sample streams: thermal core and geometry edge valid/ready pairs.
interface aion_guardian_scheduler_if;
  logic [31:0] core_temp;
  logic        core_valid;
  logic        core_ready;
  logic [31:0] edge_z;
  logic        edge_valid;
  logic        edge_ready;

  modport master (
    output core_temp, core_valid, edge_z, edge_valid,
    input  core_ready, edge_ready
  );

  modport slave (
    input  core_temp, core_valid, edge_z, edge_valid,
    output core_ready, edge_ready
  );
endinterface

// File: rtl/aion_guardian_scheduler.sv
// Guardian safety scheduler: buffers and round-robin arbitrates the thermal and
// geometry streams into one limit comparator, debounces violations, watchdogs
// both streams and runs the SCRAM latch/acknowledge state machine.
module aion_guardian_scheduler #(
  parameter logic [31:0] MIN_DIST      = 32'h0000_2666,
  parameter logic [31:0] MAX_TEMP      = 32'h0064_0000,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned STALE_TIMEOUT = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  aion_guardian_scheduler_if.slave      bus,
  input  logic                          scram_ack,
  output logic                          scram_alarm,
  output logic [2:0]                    trip_cause,
  output logic [1:0]                    state
);

  localparam int unsigned WDW = $clog2(STALE_TIMEOUT + 1);
  localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [WDW-1:0] STALE_LIM = WDW'(STALE_TIMEOUT);
  localparam logic [HW-1:0]  HOLD_LIM  = HW'(HOLD_CYCLES);
  localparam logic [3:0]     DEB       = 4'(DEBOUNCE);
  localparam logic [3:0]     DEB_M1    = 4'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PENDING = 2'd1,
    SCRAM   = 2'd2,
    RECOVER = 2'd3
  } fsm_t;

  fsm_t            state_q, state_d;
  logic            core_full, edge_full;
  logic [31:0]     core_buf, edge_buf;
  logic            rr_edge;
  logic            grant_core, grant_edge;
  logic            core_acc, edge_acc;
  logic            core_hi, edge_hi;
  logic            core_viol, edge_viol, core_ok, edge_ok, any_viol;
  logic [3:0]      cnt_core, cnt_edge;
  logic [WDW-1:0]  wd_core, wd_edge;
  logic            stale_any;
  logic            deb_pend, deb_scram;
  logic [HW-1:0]   hold_q, hold_d;
  logic            seen_core, seen_edge, seen_core_d, seen_edge_d;
  logic            alarm_d, clr_cnt;
  logic [2:0]      cause_d;

  // Ready is simply "holding register empty", so it is already a flop output.
  assign bus.core_ready = ~core_full;
  assign bus.edge_ready = ~edge_full;
  assign core_acc       = bus.core_valid & ~core_full;
  assign edge_acc       = bus.edge_valid & ~edge_full;

  // Arbiter: a lone entry wins; a contested cycle goes to the pointed channel.
  always_comb begin
    grant_core = core_full;
    grant_edge = edge_full;
    if (core_full && edge_full) begin
      grant_core = ~rr_edge;
      grant_edge = rr_edge;
    end
  end

  // Limit check on the granted sample; equality is safe.
  always_comb begin
    core_hi   = core_buf > MAX_TEMP;
    edge_hi   = edge_buf > MIN_DIST;
    core_viol = grant_core & core_hi;
    edge_viol = grant_edge & edge_hi;
    core_ok   = grant_core & ~core_hi;
    edge_ok   = grant_edge & ~edge_hi;
    any_viol  = core_viol | edge_viol;
    stale_any = (wd_core == STALE_LIM) | (wd_edge == STALE_LIM);
    deb_pend  = (core_viol & (cnt_core == DEB_M1)) | (edge_viol & (cnt_edge == DEB_M1));
    deb_scram = (core_viol & (cnt_core >= DEB)) | (edge_viol & (cnt_edge >= DEB));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARMED;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (stale_any || deb_scram) state_d = SCRAM;
        else if (deb_pend)          state_d = PENDING;
      end
      PENDING: state_d = SCRAM;
      SCRAM: begin
        if ((hold_q >= HOLD_LIM) && scram_ack) state_d = RECOVER;
      end
      RECOVER: begin
        if (any_viol || stale_any) state_d = SCRAM;
        else if ((seen_core | core_ok) && (seen_edge | edge_ok)) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  // Output / bookkeeping next values derived from the transition.
  always_comb begin
    alarm_d     = (state_d == SCRAM) || (state_d == RECOVER);
    clr_cnt     = (state_q == RECOVER) && (state_d == ARMED);
    cause_d     = trip_cause;
    hold_d      = hold_q;
    seen_core_d = '0;
    seen_edge_d = '0;
    // The tripping event itself is latched together with the leave-ARMED move.
    if (clr_cnt)
      cause_d = '0;
    else if ((state_q != ARMED) || (state_d != ARMED))
      cause_d = trip_cause | {stale_any, edge_viol, core_viol};
    if ((state_d == SCRAM) && (state_q != SCRAM))
      hold_d = '0;
    else if ((state_q == SCRAM) && (hold_q != HOLD_LIM))
      hold_d = hold_q + 1'b1;
    if (state_q == RECOVER) begin
      seen_core_d = seen_core | core_ok;
      seen_edge_d = seen_edge | edge_ok;
    end
  end

  // Registered outputs and FSM bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scram_alarm <= 1'b0;
      trip_cause  <= '0;
      hold_q      <= '0;
      seen_core   <= 1'b0;
      seen_edge   <= 1'b0;
    end else begin
      scram_alarm <= alarm_d;
      trip_cause  <= cause_d;
      hold_q      <= hold_d;
      seen_core   <= seen_core_d;
      seen_edge   <= seen_edge_d;
    end
  end

  // Holding buffers, round-robin pointer, debounce counters and watchdogs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_full <= 1'b0;
      edge_full <= 1'b0;
      core_buf  <= '0;
      edge_buf  <= '0;
      rr_edge   <= 1'b0;
      cnt_core  <= '0;
      cnt_edge  <= '0;
      wd_core   <= '0;
      wd_edge   <= '0;
    end else begin
      core_full <= core_acc | (core_full & ~grant_core);
      edge_full <= edge_acc | (edge_full & ~grant_edge);
      if (core_acc) core_buf <= bus.core_temp;
      if (edge_acc) edge_buf <= bus.edge_z;
      if (core_full && edge_full) rr_edge <= ~rr_edge;

      if (clr_cnt)                          cnt_core <= '0;
      else if (core_viol && cnt_core != 4'hF) cnt_core <= cnt_core + 4'd1;
      else if (core_ok)                     cnt_core <= '0;

      if (clr_cnt)                          cnt_edge <= '0;
      else if (edge_viol && cnt_edge != 4'hF) cnt_edge <= cnt_edge + 4'd1;
      else if (edge_ok)                     cnt_edge <= '0;

      if (core_acc)                  wd_core <= '0;
      else if (wd_core != STALE_LIM) wd_core <= wd_core + 1'b1;
      if (edge_acc)                  wd_edge <= '0;
      else if (wd_edge != STALE_LIM) wd_edge <= wd_edge + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_aion_guardian_scheduler.sv
// Directed, table-driven bench for the Guardian scheduler.
module tb_aion_guardian_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scram_ack = 1'b0;
  logic       scram_alarm;
  logic [2:0] trip_cause;
  logic [1:0] state;

  aion_guardian_scheduler_if bus ();

  aion_guardian_scheduler #(
    .MIN_DIST(32'h0000_2666),
    .MAX_TEMP(32'h0064_0000),
    .DEBOUNCE(3),
    .STALE_TIMEOUT(1024),
    .HOLD_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .scram_ack(scram_ack),
    .scram_alarm(scram_alarm),
    .trip_cause(trip_cause),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_ARMED = 2'd0, S_PEND = 2'd1, S_SCRAM = 2'd2, S_REC = 2'd3;

  typedef struct {
    logic        rst;
    logic        ch;     // 0 core, 1 edge
    logic [31:0] data;
    logic [1:0]  st;
    logic [2:0]  cause;
    logic        alarm;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.core_valid = 1'b0;
    bus.edge_valid = 1'b0;
    scram_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic send(input logic ch, input logic [31:0] d);
    int n = 0;
    while (!(ch ? bus.edge_ready : bus.core_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_wait: ready stayed 0 expected 1 (ch %0d)", ch);
    end
    if (ch) begin
      bus.edge_z = d;
      bus.edge_valid = 1'b1;
    end else begin
      bus.core_temp = d;
      bus.core_valid = 1'b1;
    end
    step();
    bus.core_valid = 1'b0;
    bus.edge_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nc, ne, it, xor_bad, t_scram;
    logic acc_c, acc_e;

    bus.core_temp = '0;
    bus.edge_z = '0;
    bus.core_valid = 1'b0;
    bus.edge_valid = 1'b0;

    // thermal debounce
    vt.push_back('{1'b1, 1'b1, 32'h0000_1000, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'h0064_0001, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'h0064_0001, S_PEND,  3'b001, 1'b0});
    // geometry: equality never trips, a safe sample clears, core interleave is independent
    vt.push_back('{1'b1, 1'b0, 32'h0032_0000, S_ARMED, 3'b000, 1'b0});
    for (int unsigned i = 0; i < 10; i++)
      vt.push_back('{1'b0, 1'b1, 32'h0000_2666, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'h0064_0000, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2667, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2667, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2666, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2667, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 32'h0064_0001, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2667, S_ARMED, 3'b000, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h0000_2667, S_PEND,  3'b010, 1'b0});

    do_reset();
    check("rst_state", state, S_ARMED);
    check("rst_alarm", scram_alarm, 1'b0);
    check("rst_cause", trip_cause, 3'b000);
    check("rst_core_ready", bus.core_ready, 1'b1);
    check("rst_edge_ready", bus.edge_ready, 1'b1);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      send(vt[i].ch, vt[i].data);
      step();
      check($sformatf("vec%0d_state", i), state, vt[i].st);
      check($sformatf("vec%0d_cause", i), trip_cause, vt[i].cause);
      check($sformatf("vec%0d_alarm", i), scram_alarm, vt[i].alarm);
    end

    // SCRAM hold / ack / recover, continuing from the geometry PENDING
    step();
    check("scram_entry_state", state, S_SCRAM);
    check("scram_entry_alarm", scram_alarm, 1'b1);
    check("scram_entry_cause", trip_cause, 3'b010);
    for (int unsigned k = 0; k < 5; k++) step();
    scram_ack = 1'b1;
    step();
    check("ack_early_state", state, S_SCRAM);
    for (int unsigned k = 0; k < 10; k++) step();
    check("ack_hold16_state", state, S_SCRAM);
    step();
    check("recover_state", state, S_REC);
    check("recover_alarm", scram_alarm, 1'b1);
    // violation in RECOVER re-enters SCRAM with a fresh hold count
    send(1'b1, 32'h0000_2667);
    step();
    check("rescram_state", state, S_SCRAM);
    for (int unsigned k = 0; k < 16; k++) step();
    check("rescram_hold16_state", state, S_SCRAM);
    step();
    check("recover2_state", state, S_REC);
    scram_ack = 1'b0;
    send(1'b0, 32'h0032_0000);
    step();
    check("recover_core_only", state, S_REC);
    send(1'b1, 32'h0000_1000);
    step();
    check("rearm_state", state, S_ARMED);
    check("rearm_alarm", scram_alarm, 1'b0);
    check("rearm_cause", trip_cause, 3'b000);

    // both streams saturated; ack in ARMED must be ignored
    do_reset();
    scram_ack = 1'b1;
    nc = 0; ne = 0; it = 0; xor_bad = 0;
    while ((nc < 20 || ne < 20) && it < 100) begin
      bus.core_valid = (nc < 20);
      bus.core_temp  = 32'h0010_0000 + 32'(nc);
      bus.edge_valid = (ne < 20);
      bus.edge_z     = 32'h0000_0100 + 32'(ne);
      acc_c = bus.core_valid & bus.core_ready;
      acc_e = bus.edge_valid & bus.edge_ready;
      if (it >= 2 && nc < 20 && ne < 20 && bus.core_ready == bus.edge_ready) xor_bad++;
      step();
      nc += int'(acc_c);
      ne += int'(acc_e);
      it++;
    end
    bus.core_valid = 1'b0;
    bus.edge_valid = 1'b0;
    scram_ack = 1'b0;
    check("tput_accepts", nc + ne, 40);
    check("tput_cycles", it, 40);
    check("tput_ready_alternate_errs", xor_bad, 0);
    check("tput_state", state, S_ARMED);
    check("tput_alarm", scram_alarm, 1'b0);

    // core stream stale
    do_reset();
    t_scram = -1;
    while (cyc < 1200 && t_scram < 0) begin
      send(1'b1, 32'h0000_1000);
      if (state == S_SCRAM) t_scram = cyc;
    end
    check("stale_reached", t_scram >= 1025 && t_scram <= 1026, 1'b1);
    check("stale_cause", trip_cause, 3'b100);
    check("stale_alarm", scram_alarm, 1'b1);

    // asynchronous reset mid-SCRAM
    rst_n = 1'b0;
    #1;
    check("async_rst_alarm", scram_alarm, 1'b0);
    check("async_rst_state", state, S_ARMED);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_core_ready", bus.core_ready, 1'b1);
    check("post_rst_edge_ready", bus.edge_ready, 1'b1);
    check("post_rst_cause", trip_cause, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aion_guardian_scheduler.md
Name: aion_guardian_scheduler

Overview:
- Sequences the Guardian safety check shared between the thermal core stream and the geometry edge stream.
- Arbitrates the two valid/ready streams into one Q16.16 comparator slot.
- Debounces violations, watchdogs both streams for staleness, and runs the SCRAM latch/acknowledge state machine that drives the plant-level scram_alarm.
- Sits between the phase-1 burn telemetry producers and the scram actuator interface.

Parameters:
- MIN_DIST, 32'h0000_2666, Q16.16 geometry limit; edge_z strictly greater trips.
- MAX_TEMP, 32'h0064_0000, Q16.16 thermal limit (100.0); core_temp strictly greater trips.
- DEBOUNCE, 3, consecutive violating samples on one channel needed to trip (1..15).
- STALE_TIMEOUT, 1024, cycles without an accepted sample on a channel before a stale trip.
- HOLD_CYCLES, 16, minimum cycles in SCRAM before an ack is honoured.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_temp  in  32  Q16.16 unsigned thermal sample
- core_valid  in  1  core sample valid
- core_ready  out  1  core sample accepted when valid&ready
- edge_z  in  32  Q16.16 unsigned z_pos sample
- edge_valid  in  1  edge sample valid
- edge_ready  out  1  edge sample accepted when valid&ready
- scram_ack  in  1  operator acknowledge, level
- scram_alarm  out  1  registered SCRAM command
- trip_cause  out  3  sticky cause: [0] thermal, [1] geometry, [2] stale
- state  out  2  0 ARMED, 1 PENDING, 2 SCRAM, 3 RECOVER

Behaviour:
- Reset (async, rst_n=0): scram_alarm=0, trip_cause=0, state=ARMED, core_ready=1, edge_ready=1, debounce counters=0, watchdogs=0, RR pointer=core.
- Holding buffers: each channel has a 1-deep holding register. ready = holding register empty. Accept on valid&ready. ready is registered and drops the cycle after an accept unless that channel's entry is granted the same cycle.
- Arbiter: one checked sample per cycle.
  - If only one channel holds an entry, it is granted.
  - If both hold entries, round-robin: the channel granted last loses, and the pointer toggles on every contested grant.
  - Grant empties the holding register; ready returns to 1 the next cycle.
- Check: the granted sample is compared against its limit in the grant cycle. The violation flag is registered one cycle later.
  - Violating sample: that channel's counter increments, saturating at 15.
  - Non-violating sample: that channel's counter clears.
  - Equality with the limit is not a violation.
- Watchdogs: each channel counter clears on accept, otherwise increments, saturating. Reaching STALE_TIMEOUT is a stale event. Watchdogs run in every state.
- ARMED: a counter reaching DEBOUNCE-1 with a further violation moves to PENDING. A stale event, or a counter reaching DEBOUNCE directly, moves to SCRAM.
- PENDING: one-cycle confirmation state for a debounced trip; next cycle go to SCRAM. Any stale event also goes to SCRAM.
- SCRAM:
  - scram_alarm=1 from the first SCRAM cycle (latency: 2 cycles from grant of the DEBOUNCE-th violating sample).
  - trip_cause bits are ORed in for every violation or stale event while in PENDING or SCRAM.
  - Hold counter starts at entry. When hold >= HOLD_CYCLES and scram_ack=1, go to RECOVER.
- RECOVER:
  - scram_alarm stays 1.
  - Requires both channels to deliver at least one non-violating sample and no stale event. Then go to ARMED, clearing scram_alarm, trip_cause and counters.
  - Any violation or stale event returns to SCRAM and restarts the hold counter.
- Simultaneous events: a thermal and a geometry trip in the same cycle set both cause bits. scram_ack in ARMED/PENDING is ignored. scram_ack held high does not bypass HOLD_CYCLES.
- Sampling continues in all states; the arbiter never stalls producers beyond the 1-deep buffer.
- Reset mid-SCRAM drops scram_alarm immediately (async); the downstream actuator latch is external.

Test Plan:
- Edge z=0x2667 sent 3 times, core z-safe at 50.0 -> PENDING after the 3rd check, scram_alarm=1 two cycles after the 3rd grant, trip_cause=3'b010.
- Edge z=0x2666 (equal) repeated 10 times -> no trip, state stays ARMED, scram_alarm=0.
- Core and edge valid every cycle for 20 cycles -> grants alternate core/edge, each ready toggles 1/0, no sample dropped (count accepts = 40).
- Core stream halted 1024 cycles while edge stays valid and safe -> SCRAM via stale, trip_cause=3'b100.
- In SCRAM, scram_ack=1 at hold=5 -> stays SCRAM. Ack at hold=16, then one safe sample per channel -> RECOVER, then ARMED, scram_alarm=0, trip_cause=0.
- rst_n pulsed low for 1 cycle mid-SCRAM -> scram_alarm=0 asynchronously, state=ARMED, both ready=1 after release.
